// File: rtl/gate_edge_monitor_if.sv
// gate_edge_monitor_if: observed gate output, clear, and the monitor's pulse/count/glitch results
interface gate_edge_monitor_if #(
  parameter int CNT_W = 8
);
  logic             Z;
  logic             CLR;
  logic             LEVEL;
  logic             RISE_P;
  logic             FALL_P;
  logic [CNT_W-1:0] RISE_CNT;
  logic [CNT_W-1:0] FALL_CNT;
  logic             GLITCH;
  modport master (
    output Z, CLR,
    input  LEVEL, RISE_P, FALL_P, RISE_CNT, FALL_CNT, GLITCH
  );
  modport slave (
    input  Z, CLR,
    output LEVEL, RISE_P, FALL_P, RISE_CNT, FALL_CNT, GLITCH
  );
endinterface

// File: rtl/gate_edge_monitor.sv
// gate_edge_monitor: samples a gate output, emits registered rise/fall pulses and saturating counts;
// define GLITCH_CHECK_EN to build the pulse-width checker that drives GLITCH.
module gate_edge_monitor #(
  parameter int CNT_W  = 8,
  parameter int MIN_HI = 2
) (
  input logic               CLK,
  input logic               RST,
  gate_edge_monitor_if.slave io
);
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d, fall_cnt_q, fall_cnt_d;
  logic             rise_det, fall_det;
  always_comb begin
    s1_d       = io.Z;
    s2_d       = s1_q;
    rise_det   = s1_q & ~s2_q;
    fall_det   = ~s1_q & s2_q;
    rise_d     = rise_det;
    fall_d     = fall_det;
    rise_cnt_d = io.CLR ? '0 : (rise_det && !(&rise_cnt_q)) ? rise_cnt_q + 1'b1 : rise_cnt_q;
    fall_cnt_d = io.CLR ? '0 : (fall_det && !(&fall_cnt_q)) ? fall_cnt_q + 1'b1 : fall_cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end
  assign io.LEVEL    = s2_q;
  assign io.RISE_P   = rise_q;
  assign io.FALL_P   = fall_q;
  assign io.RISE_CNT = rise_cnt_q;
  assign io.FALL_CNT = fall_cnt_q;
`ifdef GLITCH_CHECK_EN
  typedef enum logic {LOW, HIGH} state_t;
  localparam logic [7:0] MIN_W = MIN_HI[7:0];
  state_t     state_q;
  logic [7:0] w_q;
  logic       glitch_q;
  // HIGH is only entered on a detected rise, so leaving it coincides with the FALL_P edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LOW;
      w_q      <= '0;
      glitch_q <= 1'b0;
    end else begin
      if (io.CLR) glitch_q <= 1'b0;
      if (state_q == LOW) begin
        if (rise_det) begin
          state_q <= HIGH;
          w_q     <= 8'd1;
        end
      end else if (s1_q) begin
        w_q <= w_q + {7'd0, ~&w_q};
      end else begin
        state_q <= LOW;
        if (w_q < MIN_W && !io.CLR) glitch_q <= 1'b1;
      end
    end
  end
  assign io.GLITCH = glitch_q;
`else
  localparam int unused_min_hi = MIN_HI;
  assign io.GLITCH = 1'b0;
`endif
endmodule

// File: tb/tb_gate_edge_monitor.sv
// tb_gate_edge_monitor: randomized and directed stimulus checked against a sample-history reference model
module tb_gate_edge_monitor;
  localparam int CNT_W  = 4;
  localparam int MIN_HI = 3;
  localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef GLITCH_CHECK_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif
  logic CLK, RST;
  int   n_chk = 0, n_fail = 0;
  gate_edge_monitor_if #(.CNT_W(CNT_W)) io ();
  gate_edge_monitor #(.CNT_W(CNT_W), .MIN_HI(MIN_HI)) dut (.CLK(CLK), .RST(RST), .io(io));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic [2*CNT_W+3:0] obs;
  assign obs = {io.LEVEL, io.RISE_P, io.FALL_P, io.GLITCH, io.RISE_CNT, io.FALL_CNT};
  // Reference: history of Z samples taken since the last reset; missing samples read as 0
  bit hist[$];
  int m_rc, m_fc;
  bit m_g;
  function automatic bit ago(int k);
    return (hist.size() >= k) ? hist[hist.size()-k] : 1'b0;
  endfunction
  function automatic logic [2*CNT_W+3:0] exp_vec();
    return {ago(2), ago(2) & ~ago(3), ~ago(2) & ago(3), m_g, CNT_W'(m_rc), CNT_W'(m_fc)};
  endfunction
  always @(posedge CLK) begin
    int run;
    bit r, f;
    run = 0;
    if (RST) begin
      hist.delete();
      m_rc = 0;
      m_fc = 0;
      m_g  = 1'b0;
    end else begin
      r = ago(1) & ~ago(2);
      f = ~ago(1) & ago(2);
      if (f) for (int k = 2; ago(k); k++) run++;
      if (io.CLR) begin
        m_rc = 0;
        m_fc = 0;
        m_g  = 1'b0;
      end else begin
        m_rc = (m_rc + int'(r) > MAXC) ? MAXC : m_rc + int'(r);
        m_fc = (m_fc + int'(f) > MAXC) ? MAXC : m_fc + int'(f);
        if (GC && f && run < MIN_HI) m_g = 1'b1;
      end
      hist.push_back(io.Z);
      if (hist.size() > 300) void'(hist.pop_front());
    end
  end
  task automatic step(input bit z, input bit c, input bit r);
    io.Z  = z;
    io.CLR = c;
    RST   = r;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL reset cyc %0d: got %h want 0", i, obs); end
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL idle cyc %0d: got %h want 0", i, obs); end
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL idle_model cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
  task automatic test_single_pulse();
    int rp = 0, fp = 0, lv = 0, rp_at = -1, fp_at = -1;
    step(0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      step(i >= 1 && i <= 4, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL single_pulse cyc %0d: got %h want %h", i, obs, exp_vec()); end
      if (io.RISE_P) begin rp++; rp_at = i; end
      if (io.FALL_P) begin fp++; fp_at = i; end
      if (io.LEVEL) lv++;
    end
    n_chk++; if (rp !== 1 || rp_at !== 2) begin n_fail++; $display("FAIL single_rise_p: got %0d pulses at %0d want 1 at 2", rp, rp_at); end
    n_chk++; if (fp !== 1 || fp_at !== 6) begin n_fail++; $display("FAIL single_fall_p: got %0d pulses at %0d want 1 at 6", fp, fp_at); end
    n_chk++; if (lv !== 4) begin n_fail++; $display("FAIL single_level: got %0d high cycles want 4", lv); end
    n_chk++; if (io.RISE_CNT !== 4'd1 || io.FALL_CNT !== 4'd1 || io.GLITCH !== 1'b0) begin
      n_fail++; $display("FAIL single_counts: got r=%0d f=%0d g=%b want 1 1 0", io.RISE_CNT, io.FALL_CNT, io.GLITCH);
    end
  endtask
  task automatic test_saturation();
    int rp = 0, fp = 0;
    step(0, 1, 0);
    for (int i = 0; i < 42; i++) begin
      step(i < 40 && i % 2 == 0, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL saturation cyc %0d: got %h want %h", i, obs, exp_vec()); end
      n_chk++; if (io.RISE_P & io.FALL_P) begin n_fail++; $display("FAIL both_pulses cyc %0d: got 1 want 0", i); end
      if (io.RISE_P) rp++;
      if (io.FALL_P) fp++;
    end
    n_chk++; if (io.RISE_CNT !== 4'd15 || io.FALL_CNT !== 4'd15) begin
      n_fail++; $display("FAIL sat_counts: got r=%0d f=%0d want 15 15", io.RISE_CNT, io.FALL_CNT);
    end
    n_chk++; if (rp !== 20 || fp !== 20) begin n_fail++; $display("FAIL sat_pulses: got r=%0d f=%0d want 20 20", rp, fp); end
  endtask
  task automatic test_clr_collision();
    step(1, 0, 0);
    n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL clr_pre: got %h want %h", obs, exp_vec()); end
    step(1, 1, 0);
    n_chk++; if (io.RISE_P !== 1'b1 || io.RISE_CNT !== 4'd0 || io.FALL_CNT !== 4'd0) begin
      n_fail++; $display("FAIL clr_collision: got rp=%b r=%0d f=%0d want 1 0 0", io.RISE_P, io.RISE_CNT, io.FALL_CNT);
    end
    n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL clr_model: got %h want %h", obs, exp_vec()); end
    step(1, 0, 0);
    n_chk++; if (io.RISE_P !== 1'b0 || io.RISE_CNT !== 4'd0) begin
      n_fail++; $display("FAIL clr_after: got rp=%b r=%0d want 0 0", io.RISE_P, io.RISE_CNT);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL clr_tail cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
  task automatic test_glitch();
    step(0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(i < 2, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_short cyc %0d: got %h want %h", i, obs, exp_vec()); end
      if (i == 2) begin
        n_chk++; if (io.GLITCH !== 1'b0) begin n_fail++; $display("FAIL glitch_early: got %b want 0", io.GLITCH); end
      end
      if (i == 3) begin
        n_chk++; if (io.FALL_P !== 1'b1 || io.GLITCH !== GC) begin
          n_fail++; $display("FAIL glitch_set: got fp=%b g=%b want 1 %b", io.FALL_P, io.GLITCH, GC);
        end
      end
    end
    for (int i = 0; i < 7; i++) begin
      step(i < 3, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_long cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    n_chk++; if (io.GLITCH !== GC) begin n_fail++; $display("FAIL glitch_sticky: got %b want %b", io.GLITCH, GC); end
    step(0, 1, 0);
    n_chk++; if (io.GLITCH !== 1'b0) begin n_fail++; $display("FAIL glitch_clr: got %b want 0", io.GLITCH); end
  endtask
  task automatic test_reset_mid_pulse();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL rst_mid: got %h want 0", obs); end
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL rst_release cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    n_chk++; if (io.RISE_CNT !== 4'd1 || io.FALL_CNT !== 4'd0) begin
      n_fail++; $display("FAIL rst_rise: got r=%0d f=%0d want 1 0", io.RISE_CNT, io.FALL_CNT);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    n_chk++; if (io.FALL_CNT !== 4'd1 || io.GLITCH !== 1'b0) begin
      n_fail++; $display("FAIL rst_fall: got f=%0d g=%b want 1 0", io.FALL_CNT, io.GLITCH);
    end
  endtask
  task automatic test_random();
    bit z = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) z = ~z;
      step(z, $urandom_range(0, 24) == 0, $urandom_range(0, 119) == 0);
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
  initial begin
    io.Z   = 1'b0;
    io.CLR = 1'b0;
    RST    = 1'b1;
    test_reset();
    test_single_pulse();
    test_saturation();
    test_clr_collision();
    test_glitch();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
